// File: rtl/sr_flag_bank.sv
// Bank of WIDTH clocked set/reset flags with selectable S=R=1 resolution and sticky conflict flags.
// Define CONFLICT_COUNT_EN to add the saturating conflict_cnt output.
module sr_flag_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter int               CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             conflict_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] conflict,
  output logic             conflict_any
`ifdef CONFLICT_COUNT_EN
  ,
  output logic [CNT_W-1:0] conflict_cnt
`endif
);

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_SET    = 2'b01;
  localparam logic [1:0] MODE_RESET  = 2'b10;
  localparam logic [1:0] MODE_TOGGLE = 2'b11;

  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] conflict_next;
  logic [WIDTH-1:0] collide;

  assign collide = s & r;

  always_comb begin
    q_next = q;
    for (int i = 0; i < WIDTH; i++) begin
      unique case ({s[i], r[i]})
        2'b10:   q_next[i] = 1'b1;
        2'b01:   q_next[i] = 1'b0;
        2'b11: begin
          unique case (mode)
            MODE_HOLD:   q_next[i] = q[i];
            MODE_SET:    q_next[i] = 1'b1;
            MODE_RESET:  q_next[i] = 1'b0;
            MODE_TOGGLE: q_next[i] = ~q[i];
            default:     q_next[i] = q[i];
          endcase
        end
        default: q_next[i] = q[i];
      endcase
    end
  end

  // A conflict arriving in the clear cycle survives the clear.
  always_comb begin
    conflict_next = conflict_clr ? {WIDTH{1'b0}} : conflict;
    if (en) conflict_next = conflict_next | collide;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q        <= RESET_VAL;
      conflict <= {WIDTH{1'b0}};
    end else begin
      if (en) q <= q_next;
      conflict <= conflict_next;
    end
  end

  assign qn           = ~q;
  assign conflict_any = |conflict;

`ifdef CONFLICT_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = conflict_clr ? {CNT_W{1'b0}} : conflict_cnt;
    if (en && (|collide) && (cnt_next != CNT_MAX))
      cnt_next = cnt_next + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) conflict_cnt <= {CNT_W{1'b0}};
    else        conflict_cnt <= cnt_next;
  end
`endif

endmodule

// File: tb/tb_sr_flag_bank.sv
// Directed self-checking bench for sr_flag_bank (WIDTH=8, RESET_VAL=8'hA5, CNT_W=2).
// Counter checks are compiled in when CONFLICT_COUNT_EN is defined.
module tb_sr_flag_bank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] s = 8'h00;
  logic [7:0] r = 8'h00;
  logic       conflict_clr = 1'b0;
  logic [7:0] q, qn, conflict;
  logic       conflict_any;
`ifdef CONFLICT_COUNT_EN
  logic [1:0] conflict_cnt;
`endif

  int checks = 0;
  int errors = 0;

  sr_flag_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .s(s), .r(r),
    .conflict_clr(conflict_clr), .q(q), .qn(qn), .conflict(conflict),
    .conflict_any(conflict_any)
`ifdef CONFLICT_COUNT_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; s = 8'hFF; r = 8'h00; mode = 2'b00;
    step(); step();
    checks++; if (q !== 8'hA5) begin errors++; $display("FAIL reset_q got %h exp a5", q); end
    checks++; if (qn !== 8'h5A) begin errors++; $display("FAIL reset_qn got %h exp 5a", qn); end
    checks++; if (conflict !== 8'h00) begin errors++; $display("FAIL reset_conflict got %h exp 00", conflict); end
    checks++; if (conflict_any !== 1'b0) begin errors++; $display("FAIL reset_any got %b exp 0", conflict_any); end
    rst_n = 1'b1; s = 8'h00;
  endtask

  task automatic test_basic();
    en = 1'b1; mode = 2'b00;
    s = 8'h00; r = 8'hFF; step();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL basic_clear got %h exp 00", q); end
    s = 8'h0F; r = 8'h00; step();
    checks++; if (q !== 8'h0F) begin errors++; $display("FAIL basic_set got %h exp 0f", q); end
    checks++; if (qn !== 8'hF0) begin errors++; $display("FAIL basic_set_qn got %h exp f0", qn); end
    s = 8'h00; step();
    checks++; if (q !== 8'h0F) begin errors++; $display("FAIL basic_idle got %h exp 0f", q); end
    r = 8'h03; step();
    checks++; if (q !== 8'h0C) begin errors++; $display("FAIL basic_reset got %h exp 0c", q); end
    checks++; if (qn !== 8'hF3) begin errors++; $display("FAIL basic_reset_qn got %h exp f3", qn); end
    checks++; if (conflict !== 8'h00) begin errors++; $display("FAIL basic_no_conflict got %h exp 00", conflict); end
    r = 8'h00;
  endtask

  task automatic test_conflict();
    logic [7:0] exp_q [4];
    logic [7:0] tog_seq [3];
    exp_q[0] = 8'h0F; exp_q[1] = 8'hFF; exp_q[2] = 8'h00; exp_q[3] = 8'hF0;
    tog_seq[0] = 8'hF0; tog_seq[1] = 8'h0F; tog_seq[2] = 8'hF0;
    en = 1'b1;
    for (int m = 0; m < 3; m++) begin
      conflict_clr = 1'b1; s = 8'h0F; r = 8'hF0; step();
      conflict_clr = 1'b0;
      checks++; if (q !== 8'h0F) begin errors++; $display("FAIL conf_prep%0d got %h exp 0f", m, q); end
      mode = 2'(m); s = 8'hFF; r = 8'hFF; step();
      s = 8'h00; r = 8'h00;
      checks++; if (q !== exp_q[m]) begin errors++; $display("FAIL conf_mode%0d got %h exp %h", m, q, exp_q[m]); end
      checks++; if (conflict !== 8'hFF) begin errors++; $display("FAIL conf_flag%0d got %h exp ff", m, conflict); end
      checks++; if (conflict_any !== 1'b1) begin errors++; $display("FAIL conf_any%0d got %b exp 1", m, conflict_any); end
    end
    mode = 2'b00; conflict_clr = 1'b1; s = 8'h0F; r = 8'hF0; step();
    conflict_clr = 1'b0;
    checks++; if (conflict !== 8'h00) begin errors++; $display("FAIL conf_clr got %h exp 00", conflict); end
    mode = 2'b11; s = 8'hFF; r = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (q !== tog_seq[k]) begin errors++; $display("FAIL toggle%0d got %h exp %h", k, q, tog_seq[k]); end
      checks++; if (qn !== ~tog_seq[k]) begin errors++; $display("FAIL toggle_qn%0d got %h exp %h", k, qn, ~tog_seq[k]); end
    end
    checks++; if (conflict !== 8'hFF) begin errors++; $display("FAIL toggle_flag got %h exp ff", conflict); end
    s = 8'h00; r = 8'h00; mode = 2'b00;
  endtask

  task automatic test_enable();
    conflict_clr = 1'b1; step();
    conflict_clr = 1'b0;
    en = 1'b0; s = 8'hFF; r = 8'h00;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (q !== 8'hF0) begin errors++; $display("FAIL en_hold%0d got %h exp f0", k, q); end
    end
    r = 8'hFF; mode = 2'b11; step();
    checks++; if (q !== 8'hF0) begin errors++; $display("FAIL en_hold_conf got %h exp f0", q); end
    checks++; if (conflict !== 8'h00) begin errors++; $display("FAIL en_no_conflict got %h exp 00", conflict); end
    mode = 2'b00; r = 8'h00; en = 1'b1; step();
    checks++; if (q !== 8'hFF) begin errors++; $display("FAIL en_release got %h exp ff", q); end
    s = 8'h00;
  endtask

  task automatic test_sticky();
    en = 1'b1; mode = 2'b00;
    s = 8'h01; r = 8'h01; step();
    checks++; if (conflict !== 8'h01) begin errors++; $display("FAIL sticky_set got %h exp 01", conflict); end
    s = 8'h00; r = 8'h00; step();
    checks++; if (conflict !== 8'h01) begin errors++; $display("FAIL sticky_hold got %h exp 01", conflict); end
    conflict_clr = 1'b1; s = 8'h80; r = 8'h80; step();
    checks++; if (conflict !== 8'h80) begin errors++; $display("FAIL sticky_collide got %h exp 80", conflict); end
    checks++; if (q !== 8'hFF) begin errors++; $display("FAIL sticky_q got %h exp ff", q); end
    s = 8'h00; r = 8'h00; step();
    checks++; if (conflict !== 8'h00) begin errors++; $display("FAIL sticky_clear got %h exp 00", conflict); end
    checks++; if (conflict_any !== 1'b0) begin errors++; $display("FAIL sticky_any got %b exp 0", conflict_any); end
    conflict_clr = 1'b0;
  endtask

`ifdef CONFLICT_COUNT_EN
  task automatic test_count();
    logic [1:0] seq [5];
    seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3; seq[3] = 2'd3; seq[4] = 2'd3;
    en = 1'b1; conflict_clr = 1'b1; step();
    conflict_clr = 1'b0;
    checks++; if (conflict_cnt !== 2'd0) begin errors++; $display("FAIL cnt_zero got %0d exp 0", conflict_cnt); end
    s = 8'h01; r = 8'h01;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if (conflict_cnt !== seq[k]) begin errors++; $display("FAIL cnt_seq%0d got %0d exp %0d", k, conflict_cnt, seq[k]); end
    end
    conflict_clr = 1'b1; step();
    checks++; if (conflict_cnt !== 2'd1) begin errors++; $display("FAIL cnt_clr_conf got %0d exp 1", conflict_cnt); end
    s = 8'h00; r = 8'h00; step();
    checks++; if (conflict_cnt !== 2'd0) begin errors++; $display("FAIL cnt_clr got %0d exp 0", conflict_cnt); end
    conflict_clr = 1'b0; en = 1'b0; s = 8'hFF; r = 8'hFF; step();
    checks++; if (conflict_cnt !== 2'd0) begin errors++; $display("FAIL cnt_en_off got %0d exp 0", conflict_cnt); end
    en = 1'b1; s = 8'h00; r = 8'h00;
  endtask
`endif

  task automatic test_reset_mid();
    en = 1'b1; mode = 2'b00; s = 8'h00; r = 8'hFF; conflict_clr = 1'b0; step();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL mid_prep got %h exp 00", q); end
    mode = 2'b11; s = 8'hFF; r = 8'hFF; step();
    checks++; if (q !== 8'hFF) begin errors++; $display("FAIL mid_tog0 got %h exp ff", q); end
    rst_n = 1'b0; step();
    checks++; if (q !== 8'hA5) begin errors++; $display("FAIL mid_reset got %h exp a5", q); end
    checks++; if (qn !== 8'h5A) begin errors++; $display("FAIL mid_reset_qn got %h exp 5a", qn); end
    checks++; if (conflict !== 8'h00) begin errors++; $display("FAIL mid_reset_conf got %h exp 00", conflict); end
    rst_n = 1'b1; step();
    checks++; if (q !== 8'h5A) begin errors++; $display("FAIL mid_resume0 got %h exp 5a", q); end
    step();
    checks++; if (q !== 8'hA5) begin errors++; $display("FAIL mid_resume1 got %h exp a5", q); end
    checks++; if (conflict !== 8'hFF) begin errors++; $display("FAIL mid_conf got %h exp ff", conflict); end
    s = 8'h00; r = 8'h00; mode = 2'b00;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_conflict();
    test_enable();
    test_sticky();
`ifdef CONFLICT_COUNT_EN
    test_count();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
